block_to_byte_tx: RTL and testbench
===================================

Name: block_to_byte_tx

Overview:
Output serializer sitting directly downstream of the SEED encryption core. It captures the 128-bit ciphertext when the core signals completion and returns it to the Raspberry Pi one byte at a time, MSB byte first. Each byte uses a four-phase valid/ack handshake on the Pi pins. The Pi's ack and start pins are unreliable in pulse width, so they are synchronized and edge-detected internally.

Parameters:
NBYTES, 16, bytes per block (block width = 8*NBYTES)
SYNC_STAGES, 2, synchronizer flops on ack1 and start1 (minimum 2)

Ports:
clk  input  1  internal 100MHz clock
reset  input  1  asynchronous, active-low reset
in_en  input  1  global enable; when low, all state and outputs hold
start1  input  1  raw Pi pin; a rising edge starts a new session (abort/clear)
ciphertext  input  8*NBYTES  encrypted block from the SEED core; valid when enc_done=1
enc_done  input  1  one-cycle pulse from the SEED core: ciphertext is ready
ack1  input  1  raw Pi pin; high = byte taken, low = ready for next byte
part_out  output  8  current byte presented to the Pi
valid  output  1  high while part_out holds an unacknowledged byte
busy  output  1  high from block capture until block_done
block_done  output  1  one-cycle pulse after the last byte is released
overrun  output  1  sticky; a block arrived while busy and was dropped

Behaviour:
- Reset (reset=0, asynchronous) forces the following values:
  - part_out=0, valid=0, busy=0, block_done=0, overrun=0
  - byte count=0, FSM=IDLE
  - all synchronizer and edge-detect flops cleared
- Synchronizers: ack_s and start_s are the last flops of their SYNC_STAGES chains.
  - ack_rise = ack_s & !ack_d, where ack_d is ack_s delayed one cycle.
  - pulse_start = start_s & !start_d.
  - Synchronizer and edge flops advance only when in_en=1.
- pulse_start is a synchronous abort with priority over everything except reset:
  - FSM goes to IDLE; valid=0, busy=0, count=0, overrun=0, part_out=0.
  - An enc_done in the same cycle is ignored.
- in_en=0 freezes the FSM, shift register, counters and outputs. block_done is not extended; it is a single pulse within enabled cycles.
- FSM states: IDLE, SEND, RELEASE, FINISH.
  - IDLE, on enc_done=1: load shift register with ciphertext; part_out<=ciphertext[8*NBYTES-1 -: 8]; valid<=1; busy<=1; count<=0; go to SEND. valid is seen high the cycle after enc_done.
  - SEND: hold valid=1 and part_out until ack_rise. On ack_rise: valid<=0; shift register left by 8; count<=count+1; go to RELEASE.
  - RELEASE: wait for ack_s=0.
    - If count==NBYTES, go to FINISH.
    - Otherwise part_out<=next byte, valid<=1, go to SEND.
    - If ack1 is held high, the FSM waits indefinitely. A level-high ack never advances a second byte.
  - FINISH: block_done<=1 for one cycle; busy<=0; part_out<=0; go to IDLE.
- Latency: ack1 sampled high at edge k produces valid=0 after edge k+SYNC_STAGES (3 edges total with the default).
- enc_done in any state other than IDLE:
  - overrun<=1 (sticky until reset or pulse_start).
  - The new block is dropped; the current transfer is unaffected.
  - This includes the FINISH cycle.
- The byte counter is wide enough to hold NBYTES and never wraps within a block.
- The shift register zero-fills from the LSB side.

Test Plan:
1. Full block: ciphertext=128'h000102...0F, enc_done pulse, then 16 Pi ack cycles (ack high 5 cycles, low 5 cycles) -> part_out sequence 00,01,...,0F. valid drops 3 cycles after each ack rise. A single block_done pulse follows the 16th ack fall; busy=0 afterwards.
2. Long ack: ack1 held high 40 cycles on byte 0 -> exactly one byte advances. valid stays 0 until ack falls, then byte 01 is presented.
3. Overrun: second enc_done pulse while byte 5 is pending -> overrun=1. The remaining bytes 05..0F still come from the first block, and overrun stays 1 after block_done.
4. Abort: start1 rising edge mid-block at byte 7 -> within SYNC_STAGES+1 cycles valid=0, busy=0, overrun=0. A subsequent enc_done with ciphertext=128'hB41E...5EC7 restarts at byte B4.
5. Enable gating: in_en=0 for 10 cycles while in SEND with an ack pulse applied -> no state change and part_out held. Ack re-applied after in_en=1 -> normal advance.
6. Async reset: reset=0 mid-transfer, applied between clock edges -> all outputs 0 immediately, before the next clk edge. On release, the block is in IDLE and accepts a new enc_done.

Source files
------------

// File: rtl/block_to_byte_tx.sv
// block_to_byte_tx: captures a 128-bit SEED ciphertext and returns it to the Pi
// one byte at a time, MSB byte first, over a four-phase valid/ack handshake.
module block_to_byte_tx #(
  parameter int NBYTES      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_en,
  input  logic                start1,
  input  logic [8*NBYTES-1:0] ciphertext,
  input  logic                enc_done,
  input  logic                ack1,
  output logic [7:0]          part_out,
  output logic                valid,
  output logic                busy,
  output logic                block_done,
  output logic                overrun
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  typedef enum logic [1:0] {IDLE, SEND, RELEASE, FINISH} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d, start_sync_q, start_sync_d;
  logic                   ack_dly_q, ack_dly_d, start_dly_q, start_dly_d;
  logic [W-1:0]           shreg_q, shreg_d;
  logic [CW-1:0]          count_q, count_d;
  logic [7:0]             part_q, part_d;
  logic                   valid_q, valid_d, busy_q, busy_d;
  logic                   done_q, done_d, overrun_q, overrun_d;
  logic                   ack_s, start_s, ack_rise, pulse_start;
  assign ack_s       = ack_sync_q[SYNC_STAGES-1];
  assign start_s     = start_sync_q[SYNC_STAGES-1];
  assign ack_rise    = ack_s & ~ack_dly_q;
  assign pulse_start = start_s & ~start_dly_q;
  assign part_out    = part_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign block_done  = done_q;
  assign overrun     = overrun_q;
  always_comb begin
    ack_sync_d   = in_en ? {ack_sync_q[SYNC_STAGES-2:0], ack1} : ack_sync_q;
    start_sync_d = in_en ? {start_sync_q[SYNC_STAGES-2:0], start1} : start_sync_q;
    ack_dly_d    = in_en ? ack_s : ack_dly_q;
    start_dly_d  = in_en ? start_s : start_dly_q;
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    part_d       = part_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;
    if (in_en && pulse_start) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      count_d   = '0;
      overrun_d = 1'b0;
      part_d    = '0;
    end else if (in_en) begin
      // a block landing while one is still in flight is dropped, not queued
      if (enc_done && state_q != IDLE) overrun_d = 1'b1;
      case (state_q)
        IDLE: if (enc_done) begin
          shreg_d = ciphertext;
          part_d  = ciphertext[W-1 -: 8];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          count_d = '0;
          state_d = SEND;
        end
        SEND: if (ack_rise) begin
          valid_d = 1'b0;
          shreg_d = shreg_q << 8;
          count_d = count_q + CW'(1);
          state_d = RELEASE;
        end
        RELEASE: if (!ack_s) begin
          if (count_q == CW'(NBYTES)) state_d = FINISH;
          else begin
            part_d  = shreg_q[W-1 -: 8];
            valid_d = 1'b1;
            state_d = SEND;
          end
        end
        FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          part_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ack_sync_q   <= '0;
      start_sync_q <= '0;
      ack_dly_q    <= 1'b0;
      start_dly_q  <= 1'b0;
      shreg_q      <= '0;
      count_q      <= '0;
      part_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_sync_q   <= ack_sync_d;
      start_sync_q <= start_sync_d;
      ack_dly_q    <= ack_dly_d;
      start_dly_q  <= start_dly_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      part_q       <= part_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_block_to_byte_tx.sv
// tb_block_to_byte_tx: directed bench with a byte scoreboard for block_to_byte_tx.
module tb_block_to_byte_tx;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_en = 1'b1;
  logic         start1 = 1'b0;
  logic [127:0] ciphertext = '0;
  logic         enc_done = 1'b0;
  logic         ack1 = 1'b0;
  logic [7:0]   part_out;
  logic         valid, busy, block_done, overrun;
  int           total = 0;
  int           bad = 0;
  int           done_cnt = 0;
  logic [7:0]   exp_q[$];
  localparam logic [127:0] BLK_A = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK_B = 128'hB41E2A3C4D5E6F708192A3B4C5D65EC7;
  localparam logic [127:0] BLK_X = 128'hFFEEDDCCBBAA99887766554433221100;

  block_to_byte_tx #(.NBYTES(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .start1(start1),
    .ciphertext(ciphertext), .enc_done(enc_done), .ack1(ack1),
    .part_out(part_out), .valid(valid), .busy(busy),
    .block_done(block_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_block(input logic [127:0] ct);
    logic [127:0] t;
    t = ct;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(t[127:120]);
      t = t << 8;
    end
  endtask

  task automatic pulse_enc(input logic [127:0] ct);
    ciphertext = ct;
    enc_done = 1'b1;
    tick(1);
    enc_done = 1'b0;
  endtask

  task automatic ack_byte(input int hi, input int lo);
    logic [7:0] e;
    chk("valid_pre", {127'd0, valid}, 128'd1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", part_out);
    end else begin
      e = exp_q.pop_front();
      chk("byte", {120'd0, part_out}, {120'd0, e});
    end
    ack1 = 1'b1;
    tick(2);
    chk("valid_hold", {127'd0, valid}, 128'd1);
    tick(1);
    chk("valid_drop", {127'd0, valid}, 128'd0);
    tick(hi - 3);
    chk("valid_low_hi", {127'd0, valid}, 128'd0);
    ack1 = 1'b0;
    repeat (lo) begin
      tick(1);
      if (block_done) done_cnt++;
    end
  endtask

  initial begin
    #2;
    chk("rst_part", {120'd0, part_out}, 128'd0);
    chk("rst_flags", {124'd0, valid, busy, block_done, overrun}, 128'd0);
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("idle_flags", {124'd0, valid, busy, block_done, overrun}, 128'd0);

    // full block, 5-high/5-low acks
    push_block(BLK_A);
    pulse_enc(BLK_A);
    chk("busy_start", {127'd0, busy}, 128'd1);
    done_cnt = 0;
    for (int i = 0; i < 16; i++) ack_byte(5, 5);
    chk("done_once", 128'(done_cnt), 128'd1);
    chk("busy_end", {127'd0, busy}, 128'd0);
    chk("valid_end", {127'd0, valid}, 128'd0);
    chk("part_end", {120'd0, part_out}, 128'd0);

    // long ack on byte 0, then overrun while byte 5 pending
    push_block(BLK_A);
    pulse_enc(BLK_A);
    done_cnt = 0;
    ack_byte(40, 5);
    for (int i = 1; i < 5; i++) ack_byte(5, 5);
    chk("ovr_before", {127'd0, overrun}, 128'd0);
    pulse_enc(BLK_X);
    tick(1);
    chk("ovr_set", {127'd0, overrun}, 128'd1);
    for (int i = 5; i < 16; i++) ack_byte(5, 5);
    chk("ovr_done_once", 128'(done_cnt), 128'd1);
    chk("ovr_sticky", {127'd0, overrun}, 128'd1);

    // abort at byte 7
    push_block(BLK_A);
    pulse_enc(BLK_A);
    for (int i = 0; i < 7; i++) ack_byte(5, 5);
    chk("abort_pre_busy", {127'd0, busy}, 128'd1);
    exp_q.delete();
    start1 = 1'b1;
    tick(3);
    chk("abort_flags", {124'd0, valid, busy, block_done, overrun}, 128'd0);
    chk("abort_part", {120'd0, part_out}, 128'd0);
    start1 = 1'b0;
    tick(3);
    push_block(BLK_B);
    pulse_enc(BLK_B);
    chk("restart_b4", {120'd0, part_out}, 128'hB4);
    for (int i = 0; i < 3; i++) ack_byte(5, 5);

    // enable gating while byte 3 of block B is pending
    in_en = 1'b0;
    tick(2);
    ack1 = 1'b1;
    tick(4);
    ack1 = 1'b0;
    tick(4);
    chk("gate_valid", {127'd0, valid}, 128'd1);
    chk("gate_part", {120'd0, part_out}, 128'h3C);
    chk("gate_busy", {127'd0, busy}, 128'd1);
    in_en = 1'b1;
    tick(3);
    chk("gate_after", {120'd0, part_out}, 128'h3C);
    for (int i = 0; i < 2; i++) ack_byte(5, 5);

    // async reset between edges mid-transfer
    #2;
    reset = 1'b0;
    #1;
    chk("arst_part", {120'd0, part_out}, 128'd0);
    chk("arst_flags", {124'd0, valid, busy, block_done, overrun}, 128'd0);
    tick(2);
    reset = 1'b1;
    exp_q.delete();
    tick(2);
    push_block(BLK_A);
    pulse_enc(BLK_A);
    chk("post_rst_busy", {127'd0, busy}, 128'd1);
    for (int i = 0; i < 2; i++) ack_byte(5, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
